// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
// Sequences the register-list stack transfers (PSHS/PSHU/PULS/PULU). The 8-bit
// postbyte mask is walked one byte at a time in 6809 stacking order. Each byte
// produces one memory request and names the register and byte half involved.
// A working stack pointer is kept and written back once when the list is done.
//
// Optional build macro: STACK_SEQ_FULL_FRAME_EN
//   Adds input full_frame. When it is high on start, the mask becomes 0xFF and
//   the S stack is used, giving the 12-byte interrupt/RTI frame.
//
// Ports
//   cpu_clk, cpu_reset_n : clock, asynchronous active-low reset
//   start                : one-cycle request; sampled only in IDLE
//   pull                 : 1 = pull (load registers), 0 = push (store)
//   use_s                : 1 = S stack (bit6 = U), 0 = U stack (bit6 = S)
//   regmask              : postbyte register list
//   sp_in                : current S or U value
//   full_frame           : (macro only) force the full interrupt frame
//   mem_ack              : memory cycle complete; may come with mem_req
//   mem_req/mem_we       : request and direction, held until mem_ack
//   mem_addr             : byte address of the current access
//   reg_sel/reg_hi       : register number (TFR/EXG code) and byte half
//   reg_we               : pull only; pulses with mem_ack to load reg_sel/reg_hi
//   sp_out/sp_we         : final pointer and its one-cycle write strobe
//   busy/done            : activity flag and one-cycle completion pulse
//   dbg_state_o          : current FSM state
//
// Handshake: mem_req, mem_we, mem_addr, reg_sel and reg_hi are driven only from
// registered state and stay stable while mem_req is high. A byte completes on
// the rising edge where mem_req and mem_ack are both high; the next byte (if
// any) is presented in the following cycle with mem_req still high.
// -----------------------------------------------------------------------------
module stack_seq #(
   parameter int AW = 16
) (
   input  logic          cpu_clk,
   input  logic          cpu_reset_n,
   input  logic          start,
   input  logic          pull,
   input  logic          use_s,
   input  logic [7:0]    regmask,
   input  logic [AW-1:0] sp_in,
`ifdef STACK_SEQ_FULL_FRAME_EN
   input  logic          full_frame,
`endif
   input  logic          mem_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    reg_sel,
   output logic          reg_hi,
   output logic          reg_we,
   output logic [AW-1:0] sp_out,
   output logic          sp_we,
   output logic          busy,
   output logic          done,
   output logic [1:0]    dbg_state_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   // Register codes in TFR/EXG encoding
   localparam logic [3:0] RN_X  = 4'h1;
   localparam logic [3:0] RN_Y  = 4'h2;
   localparam logic [3:0] RN_U  = 4'h3;
   localparam logic [3:0] RN_S  = 4'h4;
   localparam logic [3:0] RN_PC = 4'h5;
   localparam logic [3:0] RN_A  = 4'h8;
   localparam logic [3:0] RN_B  = 4'h9;
   localparam logic [3:0] RN_CC = 4'hA;
   localparam logic [3:0] RN_DP = 4'hB;

   logic [1:0]    state_q,    state_d;
   logic          pull_q,     pull_d;
   logic          use_s_q,    use_s_d;
   logic [7:0]    rem_mask_q, rem_mask_d;
   logic [AW-1:0] ptr_q,      ptr_d;
   logic          second_q,   second_d;   // second byte of a 16-bit register

   logic [2:0]    cur_idx;
   logic          cur_is16;
   logic          last_byte;
   logic [7:0]    mask_eff;
   logic          use_s_eff;
   logic          in_access;

   // Effective transfer request as seen at start
`ifdef STACK_SEQ_FULL_FRAME_EN
   assign mask_eff  = full_frame ? 8'hFF : regmask;
   assign use_s_eff = full_frame ? 1'b1  : use_s;
`else
   assign mask_eff  = regmask;
   assign use_s_eff = use_s;
`endif

   // Next register to transfer: pushes take the highest remaining bit first
   // (PC end of the list), pulls take the lowest (CC end).
   always_comb begin
      cur_idx = 3'd0;
      if (pull_q) begin
         for (int i = 7; i >= 0; i--) begin
            if (rem_mask_q[i]) cur_idx = 3'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (rem_mask_q[i]) cur_idx = 3'(i);
         end
      end
   end

   // Mask bits 7..4 are the 16-bit registers PC, U/S, Y, X
   assign cur_is16  = cur_idx[2];
   assign last_byte = !cur_is16 || second_q;
   assign in_access = (state_q == ST_ACCESS);

   always_comb begin
      state_d    = state_q;
      pull_d     = pull_q;
      use_s_d    = use_s_q;
      rem_mask_d = rem_mask_q;
      ptr_d      = ptr_q;
      second_d   = second_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pull_d     = pull;
               use_s_d    = use_s_eff;
               rem_mask_d = mask_eff;
               ptr_d      = sp_in;
               second_d   = 1'b0;
               state_d    = (mask_eff != 8'h00) ? ST_ACCESS : ST_FINISH;
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               ptr_d = pull_q ? (ptr_q + PTR_ONE) : (ptr_q - PTR_ONE);
               if (last_byte) begin
                  rem_mask_d = rem_mask_q & ~(8'h01 << cur_idx);
                  second_d   = 1'b0;
                  if (rem_mask_d == 8'h00) state_d = ST_FINISH;
               end else begin
                  second_d = 1'b1;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         state_q    <= ST_IDLE;
         pull_q     <= 1'b0;
         use_s_q    <= 1'b0;
         rem_mask_q <= 8'h00;
         ptr_q      <= '0;
         second_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pull_q     <= pull_d;
         use_s_q    <= use_s_d;
         rem_mask_q <= rem_mask_d;
         ptr_q      <= ptr_d;
         second_q   <= second_d;
      end
   end

   // Register naming for the current byte. Bit6 always names the stack that
   // is not in use.
   logic [3:0] sel_raw;
   always_comb begin
      sel_raw = RN_CC;
      case (cur_idx)
         3'd0: sel_raw = RN_CC;
         3'd1: sel_raw = RN_A;
         3'd2: sel_raw = RN_B;
         3'd3: sel_raw = RN_DP;
         3'd4: sel_raw = RN_X;
         3'd5: sel_raw = RN_Y;
         3'd6: sel_raw = use_s_q ? RN_U : RN_S;
         3'd7: sel_raw = RN_PC;
         default: sel_raw = RN_CC;
      endcase
   end

   // Push stores low byte first (at the higher address), pull loads high first
   assign reg_hi   = in_access && cur_is16 && (pull_q ? !second_q : second_q);
   assign reg_sel  = in_access ? sel_raw : 4'h0;
   assign mem_req  = in_access;
   assign mem_we   = in_access && !pull_q;
   assign mem_addr = !in_access ? '0 : (pull_q ? ptr_q : (ptr_q - PTR_ONE));
   assign reg_we   = in_access && pull_q && mem_ack;

   assign done        = (state_q == ST_FINISH);
   assign sp_we       = done;
   assign sp_out      = done ? ptr_q : '0;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;

   logic        cpu_clk;
   logic        cpu_reset_n;
   logic        start;
   logic        pull;
   logic        use_s;
   logic [7:0]  regmask;
   logic [15:0] sp_in;
   logic        full_frame;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [3:0]  reg_sel;
   logic        reg_hi;
   logic        reg_we;
   logic [15:0] sp_out;
   logic        sp_we;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   stack_seq #(.AW(16)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_reset_n (cpu_reset_n),
      .start       (start),
      .pull        (pull),
      .use_s       (use_s),
      .regmask     (regmask),
      .sp_in       (sp_in),
`ifdef STACK_SEQ_FULL_FRAME_EN
      .full_frame  (full_frame),
`endif
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .reg_sel     (reg_sel),
      .reg_hi      (reg_hi),
      .reg_we      (reg_we),
      .sp_out      (sp_out),
      .sp_we       (sp_we),
      .busy        (busy),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int n_total = 0;
   int n_pass  = 0;

   // ---------------- scoreboard ----------------
   // entry = {addr[15:0], reg_sel[3:0], reg_hi}
   logic [20:0] exp_q[$];
   logic [20:0] obs_q[$];
   int          len_q[$];
   logic [15:0] exp_sp;

   // observation results of the last transfer
   int          done_cnt, done_cyc, req_cnt, waits;
   int          hold_err, we_err, regwe_err, spwe_err, busy_err;
   logic [15:0] sp_obs;
   logic [3:0]  rst_obs;

   // Reference model: the push byte stream in stacking order is
   // PCL,PCH,U/S L,H,YL,YH,XL,XH,DP,B,A,CC at descending addresses below sp.
   // A pull is the exact reverse stream at ascending addresses from sp.
   function automatic void build_exp(input bit p, input bit us, input logic [7:0] m,
                                     input logic [15:0] sp);
      logic [3:0]  tab [8];
      logic [4:0]  stream[$];
      logic [15:0] a;
      tab[7] = 4'h5; tab[6] = us ? 4'h3 : 4'h4; tab[5] = 4'h2; tab[4] = 4'h1;
      tab[3] = 4'hB; tab[2] = 4'h9; tab[1] = 4'h8; tab[0] = 4'hA;
      exp_q.delete();
      for (int b = 7; b >= 0; b--) begin
         if (m[b]) begin
            if (b >= 4) begin
               stream.push_back({tab[b], 1'b0});
               stream.push_back({tab[b], 1'b1});
            end else begin
               stream.push_back({tab[b], 1'b0});
            end
         end
      end
      for (int k = 0; k < stream.size(); k++) begin
         if (p) begin
            a = sp + 16'(k);
            exp_q.push_back({a, stream[stream.size() - 1 - k]});
         end else begin
            a = sp - 16'(k + 1);
            exp_q.push_back({a, stream[k]});
         end
      end
      exp_sp = p ? sp + 16'(stream.size()) : sp - 16'(stream.size());
   endfunction

   // ---------------- driver ----------------
   // mode: 0 zero-wait, 1 two wait cycles per byte, 2 random 0..3 waits.
   // extra_cyc: cycle at which a second start is raised (-1 none).
   // rst_after: assert reset while the byte after this many completions is up.
   task automatic run_xfer(input bit p, input bit us, input logic [7:0] m,
                           input logic [15:0] sp, input int mode, input int extra_cyc,
                           input int rst_after);
      bit          in_acc;
      int          wleft, hold;
      logic [20:0] cur;
      obs_q.delete(); len_q.delete();
      done_cnt = 0; done_cyc = -1; req_cnt = 0; waits = 0;
      hold_err = 0; we_err = 0; regwe_err = 0; spwe_err = 0; busy_err = 0;
      sp_obs = 16'h0; rst_obs = 4'hF;
      in_acc = 1'b0; wleft = 0; hold = 0; cur = '0;
      @(negedge cpu_clk);
      pull = p; use_s = us; regmask = m; sp_in = sp; start = 1'b1;
      @(posedge cpu_clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge cpu_clk);
         start = (cyc == extra_cyc);
         if (rst_after >= 0 && mem_req && obs_q.size() == rst_after) begin
            mem_ack = 1'b0;
            cpu_reset_n = 1'b0;
            #1 rst_obs = {mem_req, busy, done, sp_we};
            break;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               sp_obs = sp_out;
            end
         end
         if (sp_we !== done) spwe_err++;
         if (busy !== (done_cyc < 0 || cyc == done_cyc)) busy_err++;
         if (mem_req) begin
            req_cnt++;
            if (!in_acc) begin
               in_acc = 1'b1;
               hold = 0;
               cur = {mem_addr, reg_sel, reg_hi};
               wleft = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
            end else if ({mem_addr, reg_sel, reg_hi} !== cur) begin
               hold_err++;
            end
            if (mem_we !== !p) we_err++;
            hold++;
            if (wleft > 0) begin
               mem_ack = 1'b0;
               wleft--;
               waits++;
            end else begin
               mem_ack = 1'b1;
               obs_q.push_back(cur);
               len_q.push_back(hold);
               in_acc = 1'b0;
            end
         end else begin
            mem_ack = 1'b0;
         end
         #1;
         if (reg_we !== (p && mem_req && mem_ack)) regwe_err++;
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      start = 1'b0;
      mem_ack = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      cpu_reset_n = 1'b0; start = 1'b0; pull = 1'b0; use_s = 1'b0;
      regmask = 8'h00; sp_in = 16'h0; mem_ack = 1'b0; full_frame = 1'b0;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      n_total++;
      if ({mem_req, mem_we, reg_we, sp_we, busy, done} !== 6'b0 ||
          mem_addr !== 16'h0 || sp_out !== 16'h0 || reg_sel !== 4'h0 || reg_hi !== 1'b0)
         $display("FAIL reset_outputs: got req=%b busy=%b done=%b addr=%h sp_out=%h want all 0",
                  mem_req, busy, done, mem_addr, sp_out);
      else n_pass++;
      cpu_reset_n = 1'b1;
   endtask

   task automatic test_push_a();
      build_exp(1'b0, 1'b1, 8'h02, 16'h1000);
      run_xfer(1'b0, 1'b1, 8'h02, 16'h1000, 0, -1, -1);
      n_total++;
      if (obs_q.size() != 1 || obs_q[0] !== {16'h0FFF, 4'h8, 1'b0})
         $display("FAIL push_a_access: got n=%0d first=%h want n=1 %h", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : 21'h0, {16'h0FFF, 4'h8, 1'b0});
      else n_pass++;
      n_total++;
      if (done_cyc != 2 || sp_obs !== 16'h0FFF || done_cnt != 1)
         $display("FAIL push_a_done: got cyc=%0d sp=%h cnt=%0d want cyc=2 sp=0fff cnt=1",
                  done_cyc, sp_obs, done_cnt);
      else n_pass++;
      n_total++;
      if (we_err + spwe_err + busy_err + regwe_err != 0)
         $display("FAIL push_a_strobes: got we=%0d spwe=%0d busy=%0d regwe=%0d errors want 0",
                  we_err, spwe_err, busy_err, regwe_err);
      else n_pass++;
   endtask

   task automatic test_push_full();
      build_exp(1'b0, 1'b1, 8'hFF, 16'h2000);
      run_xfer(1'b0, 1'b1, 8'hFF, 16'h2000, 0, -1, -1);
      n_total++;
      if (obs_q.size() != 12)
         $display("FAIL push_full_count: got %0d want 12", obs_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_total++;
         if (obs_q[k] !== exp_q[k])
            $display("FAIL push_full_byte%0d: got %h want %h", k, obs_q[k], exp_q[k]);
         else n_pass++;
      end
      n_total++;
      if (done_cyc != 13 || sp_obs !== 16'h1FF4 || done_cnt != 1)
         $display("FAIL push_full_done: got cyc=%0d sp=%h cnt=%0d want cyc=13 sp=1ff4 cnt=1",
                  done_cyc, sp_obs, done_cnt);
      else n_pass++;
   endtask

   task automatic test_pull_wait();
      build_exp(1'b1, 1'b1, 8'h81, 16'h1FF4);
      run_xfer(1'b1, 1'b1, 8'h81, 16'h1FF4, 1, -1, -1);
      n_total++;
      if (obs_q.size() != 3)
         $display("FAIL pull_wait_count: got %0d want 3", obs_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_total++;
         if (obs_q[k] !== exp_q[k] || len_q[k] != 3)
            $display("FAIL pull_wait_byte%0d: got %h held %0d want %h held 3",
                     k, obs_q[k], len_q[k], exp_q[k]);
         else n_pass++;
      end
      n_total++;
      if (hold_err + regwe_err + we_err != 0)
         $display("FAIL pull_wait_stable: got hold=%0d regwe=%0d we=%0d errors want 0",
                  hold_err, regwe_err, we_err);
      else n_pass++;
      n_total++;
      if (done_cyc != 10 || sp_obs !== 16'h1FF7)
         $display("FAIL pull_wait_done: got cyc=%0d sp=%h want cyc=10 sp=1ff7", done_cyc, sp_obs);
      else n_pass++;
   endtask

   task automatic test_empty_and_ignored_start();
      run_xfer(1'b0, 1'b0, 8'h00, 16'h4321, 0, 1, -1);
      n_total++;
      if (req_cnt != 0 || done_cyc != 1 || sp_obs !== 16'h4321 || spwe_err != 0)
         $display("FAIL empty_mask: got req=%0d cyc=%0d sp=%h spwe_err=%0d want 0/1/4321/0",
                  req_cnt, done_cyc, sp_obs, spwe_err);
      else n_pass++;
      n_total++;
      if (done_cnt != 1 || busy_err != 0)
         $display("FAIL ignored_start: got done pulses=%0d busy_err=%0d want 1/0",
                  done_cnt, busy_err);
      else n_pass++;
   endtask

   task automatic test_wrap();
      build_exp(1'b0, 1'b0, 8'h10, 16'h0001);
      run_xfer(1'b0, 1'b0, 8'h10, 16'h0001, 0, -1, -1);
      n_total++;
      if (obs_q.size() != 2 || obs_q[0] !== {16'h0000, 4'h1, 1'b0} ||
          obs_q[1] !== {16'hFFFF, 4'h1, 1'b1})
         $display("FAIL wrap_push: got n=%0d want XL@0000 XH@ffff", obs_q.size());
      else n_pass++;
      n_total++;
      if (sp_obs !== 16'hFFFF || done_cyc != 3)
         $display("FAIL wrap_sp: got sp=%h cyc=%0d want ffff cyc=3", sp_obs, done_cyc);
      else n_pass++;
      build_exp(1'b1, 1'b0, 8'h01, 16'hFFFF);
      run_xfer(1'b1, 1'b0, 8'h01, 16'hFFFF, 0, -1, -1);
      n_total++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || sp_obs !== 16'h0000)
         $display("FAIL wrap_pull: got n=%0d sp=%h want n=1 sp=0000", obs_q.size(), sp_obs);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         bit          p, us;
         logic [7:0]  m;
         logic [15:0] sp;
         int          bad;
         p  = 1'($urandom_range(0, 1));
         us = 1'($urandom_range(0, 1));
         m  = 8'($urandom_range(0, 255));
         sp = 16'($urandom_range(0, 65535));
         build_exp(p, us, m, sp);
         run_xfer(p, us, m, sp, 2, -1, -1);
         bad = 0;
         if (obs_q.size() != exp_q.size()) bad++;
         for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            if (obs_q[k] !== exp_q[k]) bad++;
         n_total++;
         if (bad != 0)
            $display("FAIL random%0d_bytes: got %0d bytes %0d wrong want %0d bytes (p=%b m=%h sp=%h)",
                     t, obs_q.size(), bad, exp_q.size(), p, m, sp);
         else n_pass++;
         n_total++;
         if (sp_obs !== exp_sp || done_cyc != exp_q.size() + waits + 1 ||
             hold_err + regwe_err + we_err + busy_err != 0)
            $display("FAIL random%0d_done: got sp=%h cyc=%0d errs=%0d want sp=%h cyc=%0d errs=0",
                     t, sp_obs, done_cyc, hold_err + regwe_err + we_err + busy_err,
                     exp_sp, exp_q.size() + waits + 1);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      run_xfer(1'b0, 1'b1, 8'hFF, 16'h3000, 0, -1, 2);
      n_total++;
      if (rst_obs !== 4'b0000)
         $display("FAIL reset_mid_drop: got req,busy,done,spwe=%b want 0000", rst_obs);
      else n_pass++;
      @(negedge cpu_clk);
      cpu_reset_n = 1'b1;
      @(negedge cpu_clk);
      n_total++;
      if (busy !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL reset_mid_idle: got busy=%b req=%b want 0 0", busy, mem_req);
      else n_pass++;
      build_exp(1'b0, 1'b0, 8'h06, 16'h1000);
      run_xfer(1'b0, 1'b0, 8'h06, 16'h1000, 0, -1, -1);
      n_total++;
      if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] ||
          sp_obs !== 16'h0FFE || done_cyc != 3)
         $display("FAIL reset_mid_restart: got n=%0d sp=%h cyc=%0d want n=2 sp=0ffe cyc=3",
                  obs_q.size(), sp_obs, done_cyc);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_push_a();
      test_push_full();
      test_pull_wait();
      test_empty_and_ignored_start();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
